// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helper functions for the per-port memory controller.
package mem_ctrl_pkg;

   localparam logic       CMD_READ   = 1'b0;
   localparam logic       CMD_WRITE  = 1'b1;
   localparam logic [1:0] SIZE_BYTE  = 2'd0;
   localparam logic [1:0] SIZE_HALF  = 2'd1;
   localparam logic [1:0] SIZE_WORD  = 2'd2;
   localparam logic [1:0] SIZE_DWORD = 2'd3;
   localparam logic       RESP_OK    = 1'b0;
   localparam logic       RESP_ERR   = 1'b1;

   // Widest strobe the mask helper can describe; callers truncate to their own width.
   localparam int MAX_STRB = 64;

   typedef enum logic {
      S_IDLE,
      S_WDATA
   } state_e;

   function automatic logic [MAX_STRB-1:0] size_mask(input logic [1:0] size, input int unsigned off);
      logic [MAX_STRB-1:0] base;
      base = MAX_STRB'((16'd1 << (4'd1 << size)) - 16'd1);
      return base << off;
   endfunction

   // 3-bit arithmetic wraps cleanly for size 3 (mask 3'b111).
   function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
      return (addr_lo & ((3'd1 << size) - 3'd1)) != 3'd0;
   endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Core-side command/read/write channel bundle of one memory port.
interface mem_port_ctrl_if #(
   parameter int p_ADDR_BITS = 32,
   parameter int p_DATA_BITS = 32,
   parameter int p_STRB_BITS = p_DATA_BITS / 8
);
   logic [p_ADDR_BITS-1:0] mem_addr;
   logic                   mem_cmd;
   logic [1:0]             mem_size;
   logic                   mem_valid;
   logic                   mem_ready;
   logic                   mem_r_valid;
   logic                   mem_r_ready;
   logic [p_DATA_BITS-1:0] mem_r_data;
   logic                   mem_r_resp;
   logic                   mem_w_valid;
   logic                   mem_w_ready;
   logic [p_STRB_BITS-1:0] mem_w_strb;
   logic [p_DATA_BITS-1:0] mem_w_data;
   logic                   mem_w_resp;

   modport master (
      output mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready,
             mem_w_valid, mem_w_strb, mem_w_data,
      input  mem_ready, mem_r_valid, mem_r_data, mem_r_resp, mem_w_ready, mem_w_resp
   );

   modport slave (
      input  mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready,
             mem_w_valid, mem_w_strb, mem_w_data,
      output mem_ready, mem_r_valid, mem_r_data, mem_r_resp, mem_w_ready, mem_w_resp
   );
endinterface

// File: rtl/mem_resp_fifo.sv
// Synchronous response FIFO; head is combinational and reads as zero when empty.
module mem_resp_fifo #(
   parameter int p_WIDTH = 33,
   parameter int p_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [p_WIDTH-1:0] push_data,
   input  logic               pop,
   output logic               empty,
   output logic [p_WIDTH-1:0] head
);
   localparam int PTR_BITS = $clog2(p_DEPTH);

   logic [p_WIDTH-1:0] mem_q [p_DEPTH];
   logic [p_WIDTH-1:0] mem_d [p_DEPTH];
   logic [PTR_BITS:0]  wr_q, wr_d, rd_q, rd_d;
   logic               full;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[PTR_BITS] != rd_q[PTR_BITS]) &&
                  (wr_q[PTR_BITS-1:0] == rd_q[PTR_BITS-1:0]);
   assign head  = empty ? '0 : mem_q[rd_q[PTR_BITS-1:0]];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push && !full) begin
         mem_d[wr_q[PTR_BITS-1:0]] = push_data;
         wr_d = wr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < p_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

   // The controller's credit count keeps this from ever firing.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/mem_port_ctrl.sv
// Bridges the core cmd/read/write channels to a synchronous SRAM-style array port.
//   state   | meaning
//   S_IDLE  | accepting reads, and writes whose data arrives with the command
//   S_WDATA | write command latched, waiting for its write data
module mem_port_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int p_ADDR_BITS  = 32,
   parameter int p_DATA_BITS  = 32,
   parameter int p_STRB_BITS  = p_DATA_BITS / 8,
   parameter int p_RD_LATENCY = 1,
   parameter int p_RQ_DEPTH   = 4,
   parameter int p_MEM_BYTES  = 262144
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_port_ctrl_if.slave         bus,
   output logic [p_ADDR_BITS-1:0] addr,
   output logic                   rden,
   input  logic [p_DATA_BITS-1:0] rddata,
   output logic                   wren,
   output logic [p_STRB_BITS-1:0] wrstrb,
   output logic [p_DATA_BITS-1:0] wrdata
);
   localparam int OFF_BITS = (p_STRB_BITS > 1) ? $clog2(p_STRB_BITS) : 1;
   localparam int CNT_BITS = $clog2(p_RQ_DEPTH) + 1;
   localparam logic [p_ADDR_BITS-1:0] ALIGN = ~p_ADDR_BITS'(p_STRB_BITS - 1);

   state_e                 state_q, state_d;
   logic [CNT_BITS-1:0]    cnt_q, cnt_d;
   logic [p_ADDR_BITS-1:0] waddr_q, waddr_d;
   logic [p_STRB_BITS-1:0] wmask_q, wmask_d;
   logic                   werr_q, werr_d;
   logic                   w_resp_q, w_resp_d;

   logic [OFF_BITS-1:0]    byte_off;
   logic [p_ADDR_BITS-1:0] cmd_addr;
   logic [p_STRB_BITS-1:0] cmd_mask;
   logic                   cmd_err;
   logic                   rd_acc, pop, push, push_err, pipe_empty, fifo_empty;
   logic [p_DATA_BITS-1:0] push_data;
   logic [p_DATA_BITS:0]   fifo_head;

   always_comb begin
      byte_off = (p_STRB_BITS > 1) ? bus.mem_addr[OFF_BITS-1:0] : '0;
      cmd_addr = bus.mem_addr & ALIGN;
      cmd_mask = p_STRB_BITS'(size_mask(bus.mem_size, 32'(byte_off)));
      cmd_err  = is_misaligned(bus.mem_addr[2:0], bus.mem_size)
              || ((64'(bus.mem_addr) + (64'd1 << bus.mem_size)) > 64'(p_MEM_BYTES))
              || ((32'd1 << bus.mem_size) > 32'(p_STRB_BITS));
   end

   always_comb begin
      state_d         = state_q;
      waddr_d         = waddr_q;
      wmask_d         = wmask_q;
      werr_d          = werr_q;
      w_resp_d        = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.mem_w_ready = 1'b0;
      rd_acc          = 1'b0;
      rden            = 1'b0;
      wren            = 1'b0;
      addr            = '0;
      wrstrb          = '0;
      wrdata          = '0;
      if (rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.mem_cmd == CMD_READ) bus.mem_ready = (cnt_q < CNT_BITS'(p_RQ_DEPTH));
               else                         bus.mem_ready = pipe_empty;
               if (bus.mem_valid && bus.mem_ready) begin
                  addr = cmd_addr;
                  if (bus.mem_cmd == CMD_READ) begin
                     rd_acc = 1'b1;
                     rden   = !cmd_err;
                  end else begin
                     bus.mem_w_ready = 1'b1;
                     if (bus.mem_w_valid) begin
                        wren     = !cmd_err;
                        wrstrb   = bus.mem_w_strb & cmd_mask;
                        wrdata   = bus.mem_w_data;
                        w_resp_d = cmd_err;
                     end else begin
                        waddr_d = cmd_addr;
                        wmask_d = cmd_mask;
                        werr_d  = cmd_err;
                        state_d = S_WDATA;
                     end
                  end
               end
            end
            S_WDATA: begin
               bus.mem_w_ready = 1'b1;
               addr            = waddr_q;
               if (bus.mem_w_valid) begin
                  wren     = !werr_q;
                  wrstrb   = bus.mem_w_strb & wmask_q;
                  wrdata   = bus.mem_w_data;
                  w_resp_d = werr_q;
                  state_d  = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Read tags ride a shift register matching the array latency; the tail pushes into the FIFO.
   generate
      if (p_RD_LATENCY == 0) begin : g_no_pipe
         assign pipe_empty = 1'b1;
         assign push       = rd_acc;
         assign push_err   = cmd_err;
      end else begin : g_pipe
         logic [p_RD_LATENCY-1:0] vld_q, vld_d, err_q, err_d;
         always_comb begin
            vld_d = (vld_q << 1) | p_RD_LATENCY'(rd_acc);
            err_d = (err_q << 1) | p_RD_LATENCY'(cmd_err);
         end
         always_ff @(posedge clk) begin
            if (!rst) begin
               vld_q <= '0;
               err_q <= '0;
            end else begin
               vld_q <= vld_d;
               err_q <= err_d;
            end
         end
         assign pipe_empty = (vld_q == '0);
         assign push       = vld_q[p_RD_LATENCY-1];
         assign push_err   = err_q[p_RD_LATENCY-1];
      end
   endgenerate

   assign push_data = (push_err == RESP_ERR) ? '0 : rddata;
   assign pop       = bus.mem_r_valid && bus.mem_r_ready;
   assign cnt_d     = cnt_q + CNT_BITS'(rd_acc) - CNT_BITS'(pop);

   mem_resp_fifo #(
      .p_WIDTH (p_DATA_BITS + 1),
      .p_DEPTH (p_RQ_DEPTH)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({push_data, push_err}),
      .pop       (pop),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign bus.mem_r_valid = rst && !fifo_empty;
   assign bus.mem_r_data  = rst ? fifo_head[p_DATA_BITS:1] : '0;
   assign bus.mem_r_resp  = rst && fifo_head[0];
   assign bus.mem_w_resp  = w_resp_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         waddr_q  <= '0;
         wmask_q  <= '0;
         werr_q   <= 1'b0;
         w_resp_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         waddr_q  <= waddr_d;
         wmask_q  <= wmask_d;
         werr_q   <= werr_d;
         w_resp_q <= w_resp_d;
      end
   end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a latency-1 byte-writable array model.
module tb_mem_port_ctrl;
   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        rden;
   logic [31:0] rddata;
   logic        wren;
   logic [3:0]  wrstrb;
   logic [31:0] wrdata;

   int checks;
   int errors;
   int cyc;

   logic [31:0] mem [256];

   mem_port_ctrl_if #(.p_ADDR_BITS(32), .p_DATA_BITS(32), .p_STRB_BITS(4)) bus ();

   mem_port_ctrl #(
      .p_ADDR_BITS  (32),
      .p_DATA_BITS  (32),
      .p_STRB_BITS  (4),
      .p_RD_LATENCY (1),
      .p_RQ_DEPTH   (4),
      .p_MEM_BYTES  (262144)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .addr   (addr),
      .rden   (rden),
      .rddata (rddata),
      .wren   (wren),
      .wrstrb (wrstrb),
      .wrdata (wrdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Array model: word i preloads to 0x1000_0000 + i; reads return one cycle after rden.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc == 0) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
      end else begin
         if (wren) begin
            for (int b = 0; b < 4; b++)
               if (wrstrb[b]) mem[addr[9:2]][8*b +: 8] <= wrdata[8*b +: 8];
         end
         if (rden) rddata <= mem[addr[9:2]];
      end
   end

   typedef struct {
      logic        cmd;
      logic [31:0] a;
      logic [1:0]  sz;
      logic [3:0]  strb;
      logic [31:0] wd;
      logic        en;
      logic [31:0] ea;
      logic [3:0]  es;
      logic [31:0] ed;
      logic        err;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (!bus.mem_ready && n < 10) begin
         tick;
         #3;
         n++;
      end
      chk({nm, " mem_ready"}, 64'(bus.mem_ready), 64'd1);
   endtask

   task automatic do_read(input string nm, input logic [31:0] a, input logic [1:0] sz,
                          input logic en, input logic [31:0] ea, input logic [31:0] ed,
                          input logic er);
      int   lat;
      logic got;
      bus.mem_valid   = 1'b1;
      bus.mem_cmd     = 1'b0;
      bus.mem_addr    = a;
      bus.mem_size    = sz;
      bus.mem_w_valid = 1'b0;
      bus.mem_r_ready = 1'b1;
      #3;
      wait_ready(nm);
      chk({nm, " rden"}, 64'(rden), 64'(en));
      chk({nm, " addr"}, 64'(addr), 64'(ea));
      tick;
      bus.mem_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int k = 1; k <= 8 && !got; k++) begin
         #3;
         if (bus.mem_r_valid) begin
            got = 1'b1;
            lat = k;
            chk({nm, " r_data"}, 64'(bus.mem_r_data), 64'(ed));
            chk({nm, " r_resp"}, 64'(bus.mem_r_resp), 64'(er));
         end
         tick;
      end
      chk({nm, " latency"}, 64'(lat), 64'd2);
   endtask

   task automatic do_write(input string nm, input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] strb, input logic [31:0] wd, input logic en,
                           input logic [31:0] ea, input logic [3:0] es, input logic er);
      bus.mem_valid   = 1'b1;
      bus.mem_cmd     = 1'b1;
      bus.mem_addr    = a;
      bus.mem_size    = sz;
      bus.mem_w_valid = 1'b1;
      bus.mem_w_strb  = strb;
      bus.mem_w_data  = wd;
      #3;
      wait_ready(nm);
      chk({nm, " w_ready"}, 64'(bus.mem_w_ready), 64'd1);
      chk({nm, " wren"}, 64'(wren), 64'(en));
      chk({nm, " addr"}, 64'(addr), 64'(ea));
      if (en) begin
         chk({nm, " wrstrb"}, 64'(wrstrb), 64'(es));
         chk({nm, " wrdata"}, 64'(wrdata), 64'(wd));
      end
      tick;
      bus.mem_valid   = 1'b0;
      bus.mem_w_valid = 1'b0;
      bus.mem_cmd     = 1'b0;
      #3;
      chk({nm, " w_resp"}, 64'(bus.mem_w_resp), 64'(er));
      tick;
      #3;
      chk({nm, " w_resp pulse end"}, 64'(bus.mem_w_resp), 64'd0);
      tick;
   endtask

   logic [31:0] exp_d [5];
   logic        exp_r [5];
   int          n, seen;

   initial begin
      //          cmd  addr          sz  strb  wdata          en  exp addr      strb  exp data       err
      vecs[0]  = '{1'b0, 32'h0000_0100, 2'd2, 4'h0, 32'h0,        1'b1, 32'h0000_0100, 4'h0, 32'h1000_0040, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0102, 2'd2, 4'h0, 32'h0,        1'b0, 32'h0000_0100, 4'h0, 32'h0,         1'b1};
      vecs[2]  = '{1'b0, 32'h0004_0000, 2'd2, 4'h0, 32'h0,        1'b0, 32'h0004_0000, 4'h0, 32'h0,         1'b1};
      vecs[3]  = '{1'b0, 32'h0003_FFFC, 2'd2, 4'h0, 32'h0,        1'b1, 32'h0003_FFFC, 4'h0, 32'h1000_00FF, 1'b0};
      vecs[4]  = '{1'b0, 32'h0003_FFFE, 2'd1, 4'h0, 32'h0,        1'b1, 32'h0003_FFFC, 4'h0, 32'h1000_00FF, 1'b0};
      vecs[5]  = '{1'b0, 32'h0003_FFFF, 2'd0, 4'h0, 32'h0,        1'b1, 32'h0003_FFFC, 4'h0, 32'h1000_00FF, 1'b0};
      vecs[6]  = '{1'b0, 32'h0003_FFFF, 2'd1, 4'h0, 32'h0,        1'b0, 32'h0003_FFFC, 4'h0, 32'h0,         1'b1};
      vecs[7]  = '{1'b0, 32'h0000_0008, 2'd3, 4'h0, 32'h0,        1'b0, 32'h0000_0008, 4'h0, 32'h0,         1'b1};
      vecs[8]  = '{1'b0, 32'h0000_0105, 2'd0, 4'h0, 32'h0,        1'b1, 32'h0000_0104, 4'h0, 32'h1000_0041, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0203, 2'd0, 4'hF, 32'hAA00_0000, 1'b1, 32'h0000_0200, 4'h8, 32'h0,        1'b0};
      vecs[10] = '{1'b1, 32'h0000_0302, 2'd1, 4'hF, 32'h1234_5678, 1'b1, 32'h0000_0300, 4'hC, 32'h0,        1'b0};
      vecs[11] = '{1'b1, 32'h0000_0301, 2'd1, 4'hF, 32'h9999_9999, 1'b0, 32'h0000_0300, 4'h0, 32'h0,        1'b1};
      vecs[12] = '{1'b1, 32'h0000_0304, 2'd2, 4'h5, 32'hAABB_CCDD, 1'b1, 32'h0000_0304, 4'h5, 32'h0,        1'b0};
      vecs[13] = '{1'b1, 32'h0000_030A, 2'd1, 4'h3, 32'hFFFF_FFFF, 1'b1, 32'h0000_0308, 4'h0, 32'h0,        1'b0};
      vecs[14] = '{1'b1, 32'h0004_0000, 2'd0, 4'hF, 32'h7777_7777, 1'b0, 32'h0004_0000, 4'h0, 32'h0,        1'b1};
      vecs[15] = '{1'b1, 32'h0000_0008, 2'd3, 4'hF, 32'h6666_6666, 1'b0, 32'h0000_0008, 4'h0, 32'h0,        1'b1};
      vecs[16] = '{1'b0, 32'h0000_0200, 2'd2, 4'h0, 32'h0,        1'b1, 32'h0000_0200, 4'h0, 32'hAA00_0080, 1'b0};
      vecs[17] = '{1'b0, 32'h0000_0300, 2'd2, 4'h0, 32'h0,        1'b1, 32'h0000_0300, 4'h0, 32'h1234_00C0, 1'b0};
      vecs[18] = '{1'b0, 32'h0000_0304, 2'd2, 4'h0, 32'h0,        1'b1, 32'h0000_0304, 4'h0, 32'h10BB_00DD, 1'b0};
      vecs[19] = '{1'b0, 32'h0000_0308, 2'd2, 4'h0, 32'h0,        1'b1, 32'h0000_0308, 4'h0, 32'h1000_00C2, 1'b0};

      checks = 0;
      errors = 0;
      rst             = 1'b0;
      bus.mem_valid   = 1'b1;
      bus.mem_cmd     = 1'b1;
      bus.mem_addr    = 32'h100;
      bus.mem_size    = 2'd2;
      bus.mem_w_valid = 1'b1;
      bus.mem_w_strb  = 4'hF;
      bus.mem_w_data  = 32'h5A5A_5A5A;
      bus.mem_r_ready = 1'b1;

      // Reset holds every output quiet even with a valid write presented.
      tick; tick; tick;
      #3;
      chk("rst mem_ready", 64'(bus.mem_ready), 64'd0);
      chk("rst r_valid", 64'(bus.mem_r_valid), 64'd0);
      chk("rst w_ready", 64'(bus.mem_w_ready), 64'd0);
      chk("rst w_resp", 64'(bus.mem_w_resp), 64'd0);
      chk("rst rden", 64'(rden), 64'd0);
      chk("rst wren", 64'(wren), 64'd0);
      chk("rst r_data", 64'(bus.mem_r_data), 64'd0);
      chk("rst r_resp", 64'(bus.mem_r_resp), 64'd0);
      chk("rst addr", 64'(addr), 64'd0);
      bus.mem_valid   = 1'b0;
      bus.mem_w_valid = 1'b0;
      bus.mem_cmd     = 1'b0;
      tick;
      rst = 1'b1;
      tick;

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].cmd)
            do_write($sformatf("vec%0d", i), vecs[i].a, vecs[i].sz, vecs[i].strb, vecs[i].wd,
                     vecs[i].en, vecs[i].ea, vecs[i].es, vecs[i].err);
         else
            do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].sz, vecs[i].en, vecs[i].ea,
                    vecs[i].ed, vecs[i].err);
      end

      // Back-to-back reads with the response side stalled: credit stops at four.
      bus.mem_r_ready = 1'b0;
      bus.mem_cmd     = 1'b0;
      bus.mem_size    = 2'd2;
      for (int i = 0; i < 4; i++) begin
         bus.mem_valid = 1'b1;
         bus.mem_addr  = 32'(i * 4);
         #3;
         chk($sformatf("b2b accept%0d ready", i), 64'(bus.mem_ready), 64'd1);
         chk($sformatf("b2b accept%0d rden", i), 64'(rden), 64'd1);
         tick;
      end
      bus.mem_addr = 32'h10;
      #3;
      chk("b2b fifth blocked c1", 64'(bus.mem_ready), 64'd0);
      tick;
      #3;
      chk("b2b fifth blocked c2", 64'(bus.mem_ready), 64'd0);
      tick;
      bus.mem_r_ready = 1'b1;
      #3;
      chk("b2b pop cycle ready", 64'(bus.mem_ready), 64'd0);
      chk("b2b resp0 valid", 64'(bus.mem_r_valid), 64'd1);
      chk("b2b resp0 data", 64'(bus.mem_r_data), 64'h1000_0000);
      tick;
      #3;
      chk("b2b credit back ready", 64'(bus.mem_ready), 64'd1);
      chk("b2b resp1 data", 64'(bus.mem_r_data), 64'h1000_0001);
      tick;
      bus.mem_valid = 1'b0;
      exp_d[0] = 32'h1000_0002;
      exp_d[1] = 32'h1000_0003;
      exp_d[2] = 32'h1000_0004;
      n = 0;
      for (int k = 0; k < 12 && n < 3; k++) begin
         #3;
         if (bus.mem_r_valid) begin
            chk($sformatf("b2b drain%0d data", n), 64'(bus.mem_r_data), 64'(exp_d[n]));
            n++;
         end
         tick;
      end
      chk("b2b drain count", 64'(n), 64'd3);

      // Write command whose data arrives three cycles later.
      bus.mem_valid   = 1'b1;
      bus.mem_cmd     = 1'b1;
      bus.mem_addr    = 32'h310;
      bus.mem_size    = 2'd2;
      bus.mem_w_valid = 1'b0;
      #3;
      chk("late wr cmd ready", 64'(bus.mem_ready), 64'd1);
      chk("late wr cmd wren", 64'(wren), 64'd0);
      tick;
      bus.mem_valid = 1'b0;
      bus.mem_cmd   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #3;
         chk($sformatf("late wr wait%0d ready", k), 64'(bus.mem_ready), 64'd0);
         chk($sformatf("late wr wait%0d w_ready", k), 64'(bus.mem_w_ready), 64'd1);
         chk($sformatf("late wr wait%0d wren", k), 64'(wren), 64'd0);
         tick;
      end
      bus.mem_w_valid = 1'b1;
      bus.mem_w_strb  = 4'hF;
      bus.mem_w_data  = 32'h5566_7788;
      #3;
      chk("late wr data wren", 64'(wren), 64'd1);
      chk("late wr data addr", 64'(addr), 64'h310);
      chk("late wr data wrstrb", 64'(wrstrb), 64'hF);
      tick;
      bus.mem_w_valid = 1'b0;
      #3;
      chk("late wr w_resp", 64'(bus.mem_w_resp), 64'd0);
      chk("late wr back idle", 64'(bus.mem_ready), 64'd1);
      tick;
      do_read("late wr readback", 32'h310, 2'd2, 1'b1, 32'h310, 32'h5566_7788, 1'b0);

      // Errored write command with late data keeps its latched error.
      bus.mem_valid   = 1'b1;
      bus.mem_cmd     = 1'b1;
      bus.mem_addr    = 32'h311;
      bus.mem_size    = 2'd2;
      bus.mem_w_valid = 1'b0;
      #3;
      chk("late err cmd ready", 64'(bus.mem_ready), 64'd1);
      tick;
      bus.mem_valid   = 1'b0;
      bus.mem_cmd     = 1'b0;
      bus.mem_w_valid = 1'b1;
      #3;
      chk("late err wren", 64'(wren), 64'd0);
      tick;
      bus.mem_w_valid = 1'b0;
      #3;
      chk("late err w_resp", 64'(bus.mem_w_resp), 64'd1);
      tick;

      // Errored reads interleaved with good ones keep response order.
      bus.mem_r_ready = 1'b0;
      bus.mem_cmd     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_valid = 1'b1;
         bus.mem_size  = 2'd2;
         case (i)
            0: bus.mem_addr = 32'h108;
            1: bus.mem_addr = 32'h102;
            2: bus.mem_addr = 32'h10C;
            default: bus.mem_addr = 32'h0004_0000;
         endcase
         #3;
         chk($sformatf("order accept%0d ready", i), 64'(bus.mem_ready), 64'd1);
         tick;
      end
      bus.mem_valid = 1'b0;
      exp_d[0] = 32'h1000_0042; exp_r[0] = 1'b0;
      exp_d[1] = 32'h0;         exp_r[1] = 1'b1;
      exp_d[2] = 32'h1000_0043; exp_r[2] = 1'b0;
      exp_d[3] = 32'h0;         exp_r[3] = 1'b1;
      tick; tick;
      bus.mem_r_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 12 && n < 4; k++) begin
         #3;
         if (bus.mem_r_valid) begin
            chk($sformatf("order resp%0d data", n), 64'(bus.mem_r_data), 64'(exp_d[n]));
            chk($sformatf("order resp%0d resp", n), 64'(bus.mem_r_resp), 64'(exp_r[n]));
            n++;
         end
         tick;
      end
      chk("order resp count", 64'(n), 64'd4);

      // Reset with three reads in flight discards them all.
      bus.mem_r_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.mem_valid = 1'b1;
         bus.mem_addr  = 32'h120 + 32'(i * 4);
         #3;
         chk($sformatf("flush accept%0d ready", i), 64'(bus.mem_ready), 64'd1);
         tick;
      end
      bus.mem_valid = 1'b0;
      rst = 1'b0;
      tick; tick;
      rst = 1'b1;
      bus.mem_r_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         #3;
         if (bus.mem_r_valid) seen++;
         tick;
      end
      chk("flush no stale resp", 64'(seen), 64'd0);
      do_read("post flush read", 32'h114, 2'd2, 1'b1, 32'h114, 32'h1000_0045, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
